// File: rtl/fpu_hdiv_iter_pkg.sv
// Shared definitions for the half-precision FP execution units.
// Holds the canonical NaN, the divider iteration count, fflags bit indices
// and struct, the divider FSM states, rounding-mode encodings and a binary16
// unpack helper.
// Optional build macro: FPU_HDIV_SUBNORM_EN. When it is defined, subnormal
// operands are normalised during unpack. When it is not defined, subnormal
// operands read as signed zero.
package fpu_hdiv_iter_pkg;

  localparam logic [15:0] HALF_QNAN_CANON = 16'h7E00;
  localparam int          HDIV_ITER       = 15;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  typedef struct packed {
    logic nv;
    logic dz;
    logic of;
    logic uf;
    logic nx;
  } fpu_flags_t;

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} hdiv_state_t;

  // exp is unbiased-offset (biased value, may go <= 0 for normalised subnormals)
  typedef struct packed {
    logic              sign;
    logic signed [7:0] exp;
    logic [10:0]       sig;
    logic              zero;
    logic              inf;
    logic              nan;
    logic              snan;
  } half_unp_t;

  // Leading-zero count of an 11-bit value (11 when zero).
  function automatic logic [3:0] lzc11(input logic [10:0] v);
    lzc11 = 4'd11;
    for (int i = 0; i <= 10; i++)
      if (v[i]) lzc11 = 4'(10 - i);
  endfunction

  function automatic half_unp_t unpack_half(input logic [15:0] h);
    half_unp_t  u;
    logic [4:0] e;
    logic [9:0] f;
`ifdef FPU_HDIV_SUBNORM_EN
    logic [3:0] lz;
`endif
    e      = h[14:10];
    f      = h[9:0];
    u.sign = h[15];
    u.nan  = (e == 5'd31) && (f != '0);
    u.snan = u.nan && !f[9];
    u.inf  = (e == 5'd31) && (f == '0);
    u.exp  = $signed({3'b000, e});
    u.sig  = {1'b1, f};
`ifdef FPU_HDIV_SUBNORM_EN
    u.zero = (e == '0) && (f == '0);
    if (e == '0 && f != '0) begin
      // shift the leading one into the hidden-bit slot, pay for it in exponent
      lz    = lzc11({1'b0, f});
      u.sig = {1'b0, f} << lz;
      u.exp = 8'sd1 - $signed({4'b0000, lz});
    end
`else
    u.zero = (e == '0);
`endif
    return u;
  endfunction

endpackage

// File: rtl/fpu_half_round.sv
// Combinational binary16 rounder shared by the half-precision FP units.
// Inputs : sign, exp (signed, biased), mant (10 fraction bits, hidden one
//          implied), g/r/s guard-round-sticky, rm rounding mode.
// Outputs: result (binary16), of/uf/nx exception flags.
// Optional build macro: FPU_HDIV_SUBNORM_EN. When it is defined, tiny values
// are denormalised before rounding. When it is not defined, tiny values
// flush to signed zero with UF|NX.
module fpu_half_round
  import fpu_hdiv_iter_pkg::*;
#(
  parameter int RM_W = 3
) (
  input  logic              sign,
  input  logic signed [7:0] exp,
  input  logic [9:0]        mant,
  input  logic              g,
  input  logic              r,
  input  logic              s,
  input  logic [RM_W-1:0]   rm,
  output logic [15:0]       result,
  output logic              of,
  output logic              uf,
  output logic              nx
);

  logic [9:0]  frac;
  logic [4:0]  e5;
  logic        gg, rr, ss, tiny, inexact, inc, to_zero;
  logic [14:0] sum;
`ifdef FPU_HDIV_SUBNORM_EN
  logic signed [8:0] shw;
  logic [3:0]        sh;
  logic [24:0]       ext;
`endif

  always_comb begin
    frac = mant;
    gg   = g;
    rr   = r;
    ss   = s;
    e5   = exp[4:0];
    tiny = (exp <= 8'sd0);
`ifdef FPU_HDIV_SUBNORM_EN
    shw = 9'sd1 - 9'(exp);
    sh  = (shw > 9'sd13) ? 4'd13 : shw[3:0];
    ext = '0;
    if (tiny) begin
      // 13 is enough to push every significant bit into the sticky field
      ext  = 25'({1'b1, mant, g, r, 13'b0} >> sh);
      frac = ext[24:15];
      gg   = ext[14];
      rr   = ext[13];
      ss   = s | (|ext[12:0]);
      e5   = '0;
    end
`endif
    inexact = gg | rr | ss;
    case (RM_W'(rm))
      RM_W'(RM_RTZ): inc = 1'b0;
      RM_W'(RM_RDN): inc = sign & inexact;
      RM_W'(RM_RUP): inc = !sign & inexact;
      RM_W'(RM_RMM): inc = gg;
      default:       inc = gg & (rr | ss | frac[0]);
    endcase
    to_zero = (RM_W'(rm) == RM_W'(RM_RTZ)) ||
              (RM_W'(rm) == RM_W'(RM_RDN) && !sign) ||
              (RM_W'(rm) == RM_W'(RM_RUP) && sign);
    // adding into the packed {exp,frac} field lets a mantissa carry bump the exponent
    sum    = {e5, frac} + 15'(inc);
    result = {sign, sum};
    of     = 1'b0;
    uf     = 1'b0;
    nx     = inexact;
    if (exp >= 8'sd31 || sum[14:10] == 5'd31) begin
      of     = 1'b1;
      nx     = 1'b1;
      result = to_zero ? {sign, 15'h7BFF} : {sign, 15'h7C00};
    end
`ifdef FPU_HDIV_SUBNORM_EN
    else if (tiny) begin
      uf = inexact;
    end
`else
    else if (tiny) begin
      result = {sign, 15'h0000};
      uf     = 1'b1;
      nx     = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/fpu_hdiv_iter.sv
// Iterative binary16 divider (restoring, one quotient bit per cycle).
// Ports: CLK/nRST (async active-low), in_valid/in_ready + op_a, op_b, rm
//        operand handshake; out_valid/out_ready + result, flags {NV,DZ,OF,UF,NX}
//        result handshake.
// Specials resolve at accept and appear the next cycle; normal operands take
// 15 DIV cycles and 1 ROUND cycle.
// Optional build macro: FPU_HDIV_SUBNORM_EN turns on subnormal operand and
// result support.
module fpu_hdiv_iter
  import fpu_hdiv_iter_pkg::*;
#(
  parameter int ITER = HDIV_ITER,
  parameter int RM_W = 3
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [15:0]     op_a,
  input  logic [15:0]     op_b,
  input  logic [RM_W-1:0] rm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [15:0]     result,
  output logic [4:0]      flags
);

  hdiv_state_t       state, state_nx;
  half_unp_t         ua, ub;
  logic [3:0]        cnt;
  logic [ITER-1:0]   q, nq;
  logic [11:0]       rem;
  logic [10:0]       dvs, diff;
  logic              ge, sgn, sgn_q, sp_hit, sticky;
  logic signed [7:0] exp_q, nexp;
  logic [RM_W-1:0]   rm_q;
  logic [15:0]       sp_res, res_q, rnd_res;
  fpu_flags_t        sp_flags, flg_q, rnd_flags;

  assign ua = unpack_half(op_a);
  assign ub = unpack_half(op_b);

  // special-operand decode; order matters (inf/0 is inf without DZ)
  always_comb begin
    sgn      = ua.sign ^ ub.sign;
    sp_hit   = 1'b1;
    sp_res   = '0;
    sp_flags = '0;
    if (ua.nan || ub.nan) begin
      sp_res      = HALF_QNAN_CANON;
      sp_flags.nv = ua.snan | ub.snan;
    end else if ((ua.zero && ub.zero) || (ua.inf && ub.inf)) begin
      sp_res      = HALF_QNAN_CANON;
      sp_flags.nv = 1'b1;
    end else if (ua.inf) begin
      sp_res = {sgn, 15'h7C00};
    end else if (ub.zero) begin
      sp_res      = {sgn, 15'h7C00};
      sp_flags.dz = 1'b1;
    end else if (ub.inf || ua.zero) begin
      sp_res = {sgn, 15'h0000};
    end else begin
      sp_hit = 1'b0;
    end
  end

  // restoring step: rem < 2*dvs always, so the difference fits 11 bits
  assign ge   = (rem >= {1'b0, dvs});
  assign diff = ge ? 11'(rem - {1'b0, dvs}) : rem[10:0];

  // normalise: quotient lies in (0.5, 2)
  assign nq     = q[ITER-1] ? q : {q[ITER-2:0], 1'b0};
  assign nexp   = q[ITER-1] ? exp_q : exp_q - 8'sd1;
  assign sticky = (|nq[ITER-14:0]) | (rem != '0);

  fpu_half_round #(.RM_W(RM_W)) u_round (
    .sign   (sgn_q),
    .exp    (nexp),
    .mant   (nq[ITER-2 -: 10]),
    .g      (nq[ITER-12]),
    .r      (nq[ITER-13]),
    .s      (sticky),
    .rm     (rm_q),
    .result (rnd_res),
    .of     (rnd_flags.of),
    .uf     (rnd_flags.uf),
    .nx     (rnd_flags.nx)
  );
  assign rnd_flags.nv = 1'b0;
  assign rnd_flags.dz = 1'b0;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = sp_hit ? DONE : DIV;
      DIV:     if (cnt == 4'(ITER - 1)) state_nx = ROUND;
      ROUND:   state_nx = DONE;
      DONE:    if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt   <= '0;
      q     <= '0;
      rem   <= '0;
      dvs   <= '0;
      sgn_q <= 1'b0;
      exp_q <= '0;
      rm_q  <= '0;
      res_q <= '0;
      flg_q <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          sgn_q <= sgn;
          exp_q <= ua.exp - ub.exp + 8'sd15;
          rm_q  <= rm;
          rem   <= {1'b0, ua.sig};
          dvs   <= ub.sig;
          q     <= '0;
          cnt   <= '0;
          if (sp_hit) begin
            res_q <= sp_res;
            flg_q <= sp_flags;
          end
        end
        DIV: begin
          q   <= {q[ITER-2:0], ge};
          rem <= {diff, 1'b0};
          cnt <= cnt + 4'd1;
        end
        ROUND: begin
          res_q <= rnd_res;
          flg_q <= rnd_flags;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = res_q;
  assign flags     = flg_q;

endmodule
